axi_rd_sram_responder: RTL
==========================

// Module: axi_rd_sram_responder
// PURPOSE
// AXI4 read-channel responder (subordinate side) backed by an on-chip word SRAM.
// Sits downstream of the IFU/LSU read-bus arbiter and answers its AR/R traffic.
// Supports FIXED, INCR and WRAP bursts (arlen up to 255) and returns OKAY/SLVERR/DECERR per beat.
// Includes a testbench/loader backdoor write port for preloading the memory image.
// PARAMETERS
// DEPTH_WORDS  1024          number of 32-bit words in the array (power of 2)
// BASE_ADDR    32'h8000_0000 byte address of word 0; decode window = DEPTH_WORDS*4 bytes
// RD_LATENCY   1             cycles from AR handshake to first rvalid (>=1)
// PORTS
// clk        in   1   clock
// rst        in   1   reset, synchronous, active-high
// araddr     in   32  read start byte address
// arvalid    in   1   AR valid
// arready    out  1   AR ready
// arlen      in   8   beats-1
// arsize     in   3   log2 bytes per beat (0..2 legal)
// arburst    in   2   00 FIXED, 01 INCR, 10 WRAP, 11 reserved
// rdata      out  32  read data (full aligned word)
// rresp      out  2   00 OKAY, 10 SLVERR, 11 DECERR
// rvalid     out  1   R valid
// rready     in   1   R ready
// rlast      out  1   final beat of burst
// bd_we      in   1   backdoor write enable (loader only)
// bd_addr    in   32  backdoor byte address (word aligned, BASE-relative decode)
// bd_wdata   in   32  backdoor write data
// BEHAVIOUR
// - States: IDLE -> LAT (count RD_LATENCY-1 cycles; skipped if RD_LATENCY==1) -> BEAT -> IDLE.
// - Reset: state IDLE; arready=0, rvalid=0, rlast=0, rresp=00, rdata=0 while rst=1; arready=1 first cycle after.
// - arready=1 only in IDLE; AR handshake when arvalid&&arready latches addr/len/size/burst, counters cleared.
// - AR accepted at edge T -> rvalid=1 from edge T+RD_LATENCY; one beat per cycle while rready=1.
// - R handshake = rvalid&&rready; rdata/rresp/rlast held stable while rvalid&&!rready.
// - rlast=1 exactly on beat index arlen (8-bit beat counter, beats = arlen+1, 256 max, no wrap of counter).
// - After final handshake: rvalid=0, state IDLE, arready=1 on next cycle (no AR overlap with R).
// - Address step = 1<<arsize. FIXED: constant. INCR: addr+step, 32-bit arithmetic.
// - WRAP: boundary = (arlen+1)*step; addr = (addr & ~(boundary-1)) | ((addr+step) & (boundary-1)).
// - Error rules (checked at AR, apply to every beat, arlen+1 beats always returned):
//   arburst==11, arsize>2, or WRAP with arlen not in {1,3,7,15}, or WRAP with unaligned start -> SLVERR, rdata=0.
// - Per-beat decode: addr outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4) -> DECERR, rdata=0; else OKAY.
// - rdata = mem[(addr-BASE_ADDR)>>2]; narrow beats return the whole word, no lane shifting.
// - Backdoor write takes effect next edge; a same-cycle read of that word returns the old value.
// - Reset mid-burst: burst abandoned, rvalid drops the next cycle, memory contents retained.
// - arvalid while busy: ignored (arready=0), request must be held by the initiator.
// TESTING
// - Reset 3 cycles with arvalid=1 -> arready=0, rvalid=0 during reset; arready=1 first cycle after.
// - Preload 0x80000000..0x8000000C = 11,22,33,44; INCR arlen=3 arsize=2, rready=1 -> 11,22,33,44 back-to-back, rlast on 4th, OKAY.
// - Same burst with rready toggled 1,0,0,1... -> each beat held stable while stalled, no beat lost or duplicated.
// - WRAP arlen=3 arsize=2 araddr=0x80000008 -> data 33,44,11,22; arlen=2 WRAP -> 3 beats SLVERR rdata=0.
// - INCR arlen=1 araddr=BASE+DEPTH_WORDS*4-4 -> beat0 OKAY last word, beat1 DECERR rdata=0, rlast on beat1.
// - rst asserted during beat 2 of an arlen=7 burst -> rvalid=0 next cycle, new AR accepted and served correctly.

Source files
------------

// File: rtl/axi_rd_sram_responder.sv
// AXI4 read-channel responder backed by an on-chip word SRAM.
// Serves FIXED/INCR/WRAP bursts of up to 256 beats. Each beat carries
// OKAY, SLVERR or DECERR. A loader backdoor port preloads the array.
// Only one burst is in flight at a time; AR is refused until R finishes.
module axi_rd_sram_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  output logic        rlast,
  input  logic        bd_we,
  input  logic [31:0] bd_addr,
  input  logic [31:0] bd_wdata
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] WIN_BYTES = 32'(DEPTH_WORDS * 4);
  // Cycles spent in S_LAT. The state is bypassed when RD_LATENCY is 1;
  // the clamp only keeps the constant legal in that case.
  localparam int unsigned LAT_WAIT  = (RD_LATENCY > 1) ? RD_LATENCY - 1 : 1;
  localparam logic [15:0] LAT_LAST  = 16'(LAT_WAIT - 1);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // S_BEAT with rvalid low is the fetch slot for the first beat.
  // This gives the first rvalid RD_LATENCY edges after the AR handshake.
  typedef enum logic [1:0] {S_IDLE, S_LAT, S_BEAT} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q,  addr_d;
  logic [7:0]  len_q,   len_d;
  logic [2:0]  size_q,  size_d;
  logic [1:0]  burst_q, burst_d;
  logic        err_q,   err_d;
  logic [7:0]  beat_q,  beat_d;
  logic [15:0] lat_q,   lat_d;
  logic        rvalid_q, rvalid_d;
  logic        rlast_q,  rlast_d;
  logic [1:0]  rresp_q,  rresp_d;
  logic [31:0] rdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          ar_hs;
  logic          ar_len_ok;
  logic [31:0]   ar_mask;
  logic          ar_err;
  logic [31:0]   step;
  logic [31:0]   wrap_mask;
  logic [31:0]   addr_next;
  logic [31:0]   beat_off;
  logic          beat_in;
  logic          beat_ok;
  logic [AW-1:0] beat_idx;
  logic          load_beat;
  logic [31:0]   bd_off;
  logic          bd_hit;
  logic [AW-1:0] bd_idx;

  assign arready = (state_q == S_IDLE) && !rst;
  assign ar_hs   = arvalid && arready;

  // Classify the request once at AR time; the verdict then applies to every beat.
  always_comb begin
    ar_len_ok = (arlen == 8'd1) || (arlen == 8'd3) || (arlen == 8'd7) || (arlen == 8'd15);
    ar_mask   = (32'd1 << arsize) - 32'd1;
    ar_err    = (arburst == 2'b11) || (arsize > 3'd2) ||
                ((arburst == BURST_WRAP) && (!ar_len_ok || ((araddr & ar_mask) != 32'd0)));
  end

  // Next beat address, plus the decode and word index of the current beat.
  always_comb begin
    step      = 32'd1 << size_q;
    wrap_mask = ((32'(len_q) + 32'd1) << size_q) - 32'd1;
    case (burst_q)
      BURST_FIXED: addr_next = addr_q;
      BURST_WRAP:  addr_next = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
      default:     addr_next = addr_q + step;
    endcase
    // An address below the base wraps to a huge offset, so one compare covers both edges.
    beat_off = addr_q - BASE_ADDR;
    beat_in  = beat_off < WIN_BYTES;
    beat_idx = beat_off[AW+1:2];
    beat_ok  = !err_q && beat_in;
    bd_off   = bd_addr - BASE_ADDR;
    bd_hit   = bd_we && (bd_off < WIN_BYTES);
    bd_idx   = bd_off[AW+1:2];
  end

  // Next-state logic: AR capture, latency count, and beat issue and retire.
  always_comb begin
    // NOTE: every value driven here gets a default first. This prevents
    // latches on paths that do not assign it.
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    err_d     = err_q;
    beat_d    = beat_q;
    lat_d     = lat_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    load_beat = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ar_hs) begin
          addr_d  = araddr;
          len_d   = arlen;
          size_d  = arsize;
          burst_d = arburst;
          err_d   = ar_err;
          beat_d  = 8'd0;
          lat_d   = 16'd0;
          state_d = (RD_LATENCY > 1) ? S_LAT : S_BEAT;
        end
      end
      S_LAT: begin
        if (lat_q == LAT_LAST) state_d = S_BEAT;
        else                   lat_d   = lat_q + 16'd1;
      end
      S_BEAT: begin
        // The output register is free when it is empty or being accepted this cycle.
        if (!rvalid_q || rready) begin
          if (rvalid_q && rlast_q) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            state_d  = S_IDLE;
          end else begin
            load_beat = 1'b1;
            rvalid_d  = 1'b1;
            rlast_d   = (beat_q == len_q);
            rresp_d   = err_q ? RESP_SLVERR : (beat_in ? RESP_OKAY : RESP_DECERR);
            addr_d    = addr_next;
            if (beat_q != len_q) beat_d = beat_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and response registers, with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks. Every register then
    // sees the pre-edge value of every other register.
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      err_q    <= 1'b0;
      beat_q   <= '0;
      lat_q    <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rresp_q  <= RESP_OKAY;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      size_q   <= size_d;
      burst_q  <= burst_d;
      err_q    <= err_d;
      beat_q   <= beat_d;
      lat_q    <= lat_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      rresp_q  <= rresp_d;
    end
  end

  // SRAM array: backdoor write port and a registered read that feeds rdata.
  always_ff @(posedge clk) begin
    // NOTE: the array itself is never reset. Its contents must survive rst,
    // and a reset would stop it mapping onto an SRAM macro.
    if (bd_hit) mem[bd_idx] <= bd_wdata;
    if (rst)            rdata_q <= '0;
    else if (load_beat) rdata_q <= beat_ok ? mem[beat_idx] : 32'd0;
  end

  assign rvalid = rvalid_q;
  assign rlast  = rlast_q;
  assign rresp  = rresp_q;
  assign rdata  = rdata_q;

endmodule
